// File: rtl/dma_controller_pkg.sv
// Shared definitions for the DMA byte-copy engine: register map, CTRL/STATUS
// bit positions and the master-side FSM state encoding.
package dma_controller_pkg;

  localparam logic [2:0] REG_SRC_L = 3'd0;
  localparam logic [2:0] REG_SRC_H = 3'd1;
  localparam logic [2:0] REG_DST_L = 3'd2;
  localparam logic [2:0] REG_DST_H = 3'd3;
  localparam logic [2:0] REG_LEN   = 3'd4;
  localparam logic [2:0] REG_CTRL  = 3'd5;
  localparam logic [7:0] REG_COUNT = 8'd6;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_SRC_INC = 1;
  localparam int unsigned CTRL_DST_INC = 2;
  localparam int unsigned CTRL_ABORT   = 3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_SRC_INC = 1;
  localparam int unsigned STAT_DST_INC = 2;
  localparam int unsigned STAT_DONE    = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE
  } dma_state_e;

endpackage

// File: rtl/dma_controller_if.sv
// CPU slave port, master bus port and interrupt flag of the DMA controller.
// master = the DMA device side; slave = the system (CPU, arbiter, memories).
interface dma_controller_if;
  logic [7:0]  din;
  logic [7:0]  address;
  logic        w_en;
  logic        r_en;
  logic [7:0]  dout;
  logic        bus_req;
  logic        bus_gnt;
  logic [15:0] m_address;
  logic [7:0]  m_dout;
  logic [7:0]  m_din;
  logic        m_w_en;
  logic        m_r_en;
  logic        done_flag;
  logic        done_flag_clr;

  modport master (
    input  din, address, w_en, r_en, bus_gnt, m_din, done_flag_clr,
    output dout, bus_req, m_address, m_dout, m_w_en, m_r_en, done_flag
  );

  modport slave (
    output din, address, w_en, r_en, bus_gnt, m_din, done_flag_clr,
    input  dout, bus_req, m_address, m_dout, m_w_en, m_r_en, done_flag
  );
endinterface

// File: rtl/dma_controller_engine.sv
// Master-side FSM of the DMA: bus request, read/wait/write sequencing and the
// SRC/DST/LEN datapath that advances once per copied byte.
module dma_engine
  import dma_controller_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        src_inc,
  input  logic        dst_inc,
  input  logic        ld_src_l,
  input  logic        ld_src_h,
  input  logic        ld_dst_l,
  input  logic        ld_dst_h,
  input  logic        ld_len,
  input  logic [7:0]  wdata,
  input  logic        bus_gnt,
  input  logic [7:0]  m_din,
  output logic        busy,
  output logic        bus_req,
  output logic        m_r_en,
  output logic        m_w_en,
  output logic [15:0] m_address,
  output logic [7:0]  m_dout,
  output logic [15:0] src,
  output logic [15:0] dst,
  output logic [7:0]  len,
  output logic        done_set
);

  localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

  dma_state_e  state_q, state_d;
  logic [1:0]  wait_q, wait_d;
  logic        abort_q, abort_d;
  logic [15:0] src_q, src_d, dst_q, dst_d;
  logic [7:0]  len_q, len_d, len_m1;
  logic        busy_q, busy_d, bus_req_q, bus_req_d;
  logic        m_r_en_q, m_r_en_d, m_w_en_q, m_w_en_d;
  logic [15:0] m_address_q, m_address_d;
  logic [7:0]  m_dout_q, m_dout_d;

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    abort_d  = abort_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    m_dout_d = m_dout_q;
    done_set = 1'b0;
    len_m1   = len_q - 8'd1;

    if (ld_src_l) src_d[7:0]  = wdata;
    if (ld_src_h) src_d[15:8] = wdata;
    if (ld_dst_l) dst_d[7:0]  = wdata;
    if (ld_dst_h) dst_d[15:8] = wdata;
    if (ld_len)   len_d       = wdata;

    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          state_d = S_REQ;
          abort_d = abort;
        end
      end
      S_REQ:  if (bus_gnt) state_d = S_READ;
      S_READ: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        // m_dout_q doubles as the data register between read and write
        if (wait_q == WAIT_LAST) begin
          state_d  = S_WRITE;
          m_dout_d = m_din;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      S_WRITE: begin
        src_d = src_q + 16'(src_inc);
        dst_d = dst_q + 16'(dst_inc);
        len_d = len_m1;
        if (len_m1 == 8'd0 || abort_q) begin
          state_d  = S_DONE;
          done_set = !abort_q;
        end else if (bus_gnt) begin
          state_d = S_READ;
        end else begin
          state_d = S_REQ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        abort_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && busy_q) abort_d = 1'b1;

    // Outputs are registered, so they are derived from the next state
    busy_d    = state_d inside {S_REQ, S_READ, S_WAIT, S_WRITE};
    bus_req_d = busy_d;
    m_r_en_d  = state_d == S_READ;
    m_w_en_d  = state_d == S_WRITE;
    case (state_d)
      S_READ, S_WAIT: m_address_d = src_d;
      S_WRITE:        m_address_d = dst_d;
      default:        m_address_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wait_q      <= '0;
      abort_q     <= 1'b0;
      src_q       <= '0;
      dst_q       <= '0;
      len_q       <= '0;
      busy_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      m_r_en_q    <= 1'b0;
      m_w_en_q    <= 1'b0;
      m_address_q <= '0;
      m_dout_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      abort_q     <= abort_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      bus_req_q   <= bus_req_d;
      m_r_en_q    <= m_r_en_d;
      m_w_en_q    <= m_w_en_d;
      m_address_q <= m_address_d;
      m_dout_q    <= m_dout_d;
    end
  end

  assign busy      = busy_q;
  assign bus_req   = bus_req_q;
  assign m_r_en    = m_r_en_q;
  assign m_w_en    = m_w_en_q;
  assign m_address = m_address_q;
  assign m_dout    = m_dout_q;
  assign src       = src_q;
  assign dst       = dst_q;
  assign len       = len_q;

endmodule

// File: rtl/dma_controller.sv
// Memory-mapped DMA byte-copy engine: register file and slave decode on the
// IO window, with the bus-master sequencing delegated to dma_engine.
module dma_controller
  import dma_controller_pkg::*;
#(
  parameter logic [7:0]  DMA_ADDRESS  = 8'h10,
  parameter int unsigned READ_LATENCY = 1
) (
  input logic             clk,
  input logic             rst,
  dma_controller_if.master bus
);

  logic [7:0]  off;
  logic        hit, busy, ctrl_wr, reg_wr, done_set;
  logic        src_inc_q, src_inc_d, dst_inc_q, dst_inc_d;
  logic        done_flag_q, done_flag_d;
  logic [15:0] src, dst;
  logic [7:0]  len, rd_data;

  assign off     = bus.address - DMA_ADDRESS;
  assign hit     = off < REG_COUNT;
  assign reg_wr  = bus.w_en && hit && !busy;
  assign ctrl_wr = bus.w_en && hit && off[2:0] == REG_CTRL;

  dma_engine #(.READ_LATENCY(READ_LATENCY)) u_engine (
    .clk       (clk),
    .rst       (rst),
    .start     (ctrl_wr && bus.din[CTRL_START] && !busy),
    .abort     (ctrl_wr && bus.din[CTRL_ABORT]),
    .src_inc   (src_inc_q),
    .dst_inc   (dst_inc_q),
    .ld_src_l  (reg_wr && off[2:0] == REG_SRC_L),
    .ld_src_h  (reg_wr && off[2:0] == REG_SRC_H),
    .ld_dst_l  (reg_wr && off[2:0] == REG_DST_L),
    .ld_dst_h  (reg_wr && off[2:0] == REG_DST_H),
    .ld_len    (reg_wr && off[2:0] == REG_LEN),
    .wdata     (bus.din),
    .bus_gnt   (bus.bus_gnt),
    .m_din     (bus.m_din),
    .busy      (busy),
    .bus_req   (bus.bus_req),
    .m_r_en    (bus.m_r_en),
    .m_w_en    (bus.m_w_en),
    .m_address (bus.m_address),
    .m_dout    (bus.m_dout),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .done_set  (done_set)
  );

  always_comb begin
    src_inc_d = src_inc_q;
    dst_inc_d = dst_inc_q;
    if (ctrl_wr && !busy) begin
      src_inc_d = bus.din[CTRL_SRC_INC];
      dst_inc_d = bus.din[CTRL_DST_INC];
    end
    // Completion outranks a simultaneous clear so the event is never lost
    if (done_set)               done_flag_d = 1'b1;
    else if (bus.done_flag_clr) done_flag_d = 1'b0;
    else                        done_flag_d = done_flag_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      done_flag_q <= 1'b0;
    end else begin
      src_inc_q   <= src_inc_d;
      dst_inc_q   <= dst_inc_d;
      done_flag_q <= done_flag_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (bus.r_en && hit) begin
      case (off[2:0])
        REG_SRC_L: rd_data = src[7:0];
        REG_SRC_H: rd_data = src[15:8];
        REG_DST_L: rd_data = dst[7:0];
        REG_DST_H: rd_data = dst[15:8];
        REG_LEN:   rd_data = len;
        REG_CTRL: begin
          rd_data[STAT_BUSY]    = busy;
          rd_data[STAT_SRC_INC] = src_inc_q;
          rd_data[STAT_DST_INC] = dst_inc_q;
          rd_data[STAT_DONE]    = done_flag_q;
        end
        default: rd_data = '0;
      endcase
    end
  end

  assign bus.dout      = rd_data;
  assign bus.done_flag = done_flag_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed self-checking bench for dma_controller with a latency-1 memory model.
module tb_dma_controller;

  localparam logic [7:0] BASE = 8'h10;
  localparam logic [7:0] A_SRC_L = BASE + 8'd0, A_SRC_H = BASE + 8'd1;
  localparam logic [7:0] A_DST_L = BASE + 8'd2, A_DST_H = BASE + 8'd3;
  localparam logic [7:0] A_LEN = BASE + 8'd4, A_CTRL = BASE + 8'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   both_cnt = 0;
  int   req_idle_cnt = 0;
  int   done_rise_cyc = -1;
  logic done_prev = 1'b0;
  logic [15:0] rd_lat = '0;

  logic [15:0] rd_a_q[$];
  int          rd_c_q[$];
  logic [15:0] wr_a_q[$];
  logic [7:0]  wr_d_q[$];
  int          wr_c_q[$];

  dma_controller_if bus();

  dma_controller #(.DMA_ADDRESS(BASE), .READ_LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] memf(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(posedge clk) if (bus.m_r_en) rd_lat <= bus.m_address;
  assign bus.m_din = memf(rd_lat);

  always @(negedge clk) begin
    if (bus.m_r_en && bus.m_w_en) both_cnt++;
    if (bus.m_r_en) begin rd_a_q.push_back(bus.m_address); rd_c_q.push_back(cyc); end
    if (bus.m_w_en) begin
      wr_a_q.push_back(bus.m_address); wr_d_q.push_back(bus.m_dout); wr_c_q.push_back(cyc);
    end
    if (bus.bus_req && !bus.m_r_en && !bus.m_w_en && bus.m_address == 16'h0) req_idle_cnt++;
    if (bus.done_flag && !done_prev) done_rise_cyc = cyc;
    done_prev = bus.done_flag;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cpu_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address = a; bus.din = d; bus.w_en = 1'b1;
    @(negedge clk);
    bus.w_en = 1'b0;
  endtask

  task automatic cpu_rd(input logic [7:0] a, output logic [7:0] d);
    bus.address = a; bus.r_en = 1'b1;
    #1 d = bus.dout;
    bus.r_en = 1'b0;
  endtask

  task automatic clear_logs();
    rd_a_q.delete(); rd_c_q.delete(); wr_a_q.delete(); wr_d_q.delete(); wr_c_q.delete();
    req_idle_cnt = 0; done_rise_cyc = -1;
  endtask

  task automatic setup(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n);
    cpu_wr(A_SRC_L, s[7:0]); cpu_wr(A_SRC_H, s[15:8]);
    cpu_wr(A_DST_L, d[7:0]); cpu_wr(A_DST_H, d[15:8]);
    cpu_wr(A_LEN, n);
    clear_logs();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.bus_req && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check({tag, "_timeout"}, 1, 0);
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); bus.done_flag_clr = 1'b1;
    @(negedge clk); bus.done_flag_clr = 1'b0;
  endtask

  task automatic wait_strobe(input logic want_wr, input int count, input string tag);
    int seen = 0;
    int n = 0;
    while (seen < count && n < 500) begin
      @(negedge clk); n++;
      if (want_wr ? bus.m_w_en : bus.m_r_en) seen++;
    end
    if (seen < count) check({tag, "_timeout"}, 1, 0);
  endtask

  initial begin
    logic [7:0] r;
    int bad;
    int busy_req;
    bus.din = '0; bus.address = '0; bus.w_en = 1'b0; bus.r_en = 1'b0;
    bus.bus_gnt = 1'b1; bus.done_flag_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_outs", {bus.bus_req, bus.m_r_en, bus.m_w_en, bus.done_flag}, 0);
    check("rst_maddr", bus.m_address, 16'h0);
    check("rst_mdout", bus.m_dout, 8'h0);
    check("rst_dout", bus.dout, 8'h0);
    cpu_rd(A_CTRL, r); check("rst_status", r, 8'h00);
    busy_req = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.bus_req) busy_req++; end
    check("rst_no_req", busy_req, 0);

    // Basic 4-byte copy
    setup(16'h0100, 16'h0200, 8'd4);
    cpu_wr(A_CTRL, 8'h07);
    wait_done("basic");
    check("basic_nrd", rd_a_q.size(), 4);
    check("basic_nwr", wr_a_q.size(), 4);
    if (rd_a_q.size() == 4 && wr_a_q.size() == 4) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (rd_a_q[i] != 16'h0100 + 16'(i)) bad++;
        if (wr_a_q[i] != 16'h0200 + 16'(i)) bad++;
        if (wr_d_q[i] != memf(16'h0100 + 16'(i))) bad++;
        if (wr_c_q[i] - rd_c_q[i] != 2) bad++;
        if (i > 0 && rd_c_q[i] - rd_c_q[i-1] != 3) bad++;
      end
      check("basic_pairs_bad", bad, 0);
      check("basic_wr1_data", wr_d_q[1], 8'h5A ^ 8'h01 ^ 8'h01);
      check("basic_done_cyc", done_rise_cyc, wr_c_q[3] + 1);
    end
    cpu_rd(A_CTRL, r); check("basic_status", r, 8'h86);
    cpu_rd(A_LEN, r); check("basic_len", r, 8'h00);
    cpu_rd(A_SRC_L, r); check("basic_src_l", r, 8'h04);
    cpu_rd(A_DST_H, r); check("basic_dst_h", r, 8'h02);
    pulse_clr();
    @(negedge clk);
    check("basic_clr", bus.done_flag, 0);

    // Fill mode, LEN=0 means 256 bytes
    setup(16'h100B, 16'h2000, 8'd0);
    cpu_wr(A_CTRL, 8'h05);
    wait_done("fill");
    check("fill_nwr", wr_a_q.size(), 256);
    check("fill_nrd", rd_a_q.size(), 256);
    if (wr_a_q.size() == 256 && rd_a_q.size() == 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        if (wr_a_q[i] != 16'h2000 + 16'(i)) bad++;
        if (wr_d_q[i] != 8'h41) bad++;
        if (rd_a_q[i] != 16'h100B) bad++;
      end
      check("fill_bad", bad, 0);
    end
    cpu_rd(A_SRC_L, r); check("fill_src_l", r, 8'h0B);
    cpu_rd(A_SRC_H, r); check("fill_src_h", r, 8'h10);
    cpu_rd(A_DST_H, r); check("fill_dst_h", r, 8'h21);
    pulse_clr();

    // Grant dropped for 5 cycles after byte 2; busy writes ignored
    setup(16'h0300, 16'h0400, 8'd4);
    cpu_wr(A_CTRL, 8'h07);
    wait_strobe(1'b1, 2, "gnt");
    bus.bus_gnt = 1'b0;
    cpu_wr(A_SRC_L, 8'hEE);
    repeat (3) @(negedge clk);
    bus.bus_gnt = 1'b1;
    wait_done("gnt");
    check("gnt_nrd", rd_a_q.size(), 4);
    if (rd_a_q.size() == 4 && wr_a_q.size() == 4) begin
      check("gnt_gap", rd_c_q[2] - wr_c_q[1], 6);
      check("gnt_rd2", rd_a_q[2], 16'h0302);
      check("gnt_rd3", rd_a_q[3], 16'h0303);
      check("gnt_wr3", wr_a_q[3], 16'h0403);
    end
    check("gnt_req_cycles", req_idle_cnt, 6);
    pulse_clr();

    // Abort during WAIT of byte 2
    setup(16'h0500, 16'h0600, 8'd10);
    cpu_wr(A_CTRL, 8'h07);
    wait_strobe(1'b0, 2, "abort");
    cpu_wr(A_CTRL, 8'h08);
    wait_done("abort");
    check("abort_nwr", wr_a_q.size(), 2);
    check("abort_nrd", rd_a_q.size(), 2);
    cpu_rd(A_LEN, r); check("abort_len", r, 8'd8);
    cpu_rd(A_CTRL, r); check("abort_status", r, 8'h06);
    check("abort_done", bus.done_flag, 0);

    // Source address wrap
    setup(16'hFFFF, 16'h0700, 8'd2);
    cpu_wr(A_CTRL, 8'h07);
    wait_done("wrap");
    check("wrap_nrd", rd_a_q.size(), 2);
    if (rd_a_q.size() == 2) begin
      check("wrap_rd0", rd_a_q[0], 16'hFFFF);
      check("wrap_rd1", rd_a_q[1], 16'h0000);
    end
    pulse_clr();

    // Clear in the same cycle as set: set wins
    setup(16'h0800, 16'h0900, 8'd1);
    cpu_wr(A_CTRL, 8'h07);
    wait_strobe(1'b1, 1, "setclr");
    bus.done_flag_clr = 1'b1;
    @(negedge clk);
    bus.done_flag_clr = 1'b0;
    check("setclr_flag", bus.done_flag, 1);
    pulse_clr();
    @(negedge clk);
    check("setclr_after", bus.done_flag, 0);

    // Reset asserted mid-WRITE
    setup(16'h0A00, 16'h0B00, 8'd4);
    cpu_wr(A_CTRL, 8'h07);
    wait_strobe(1'b1, 1, "rstmid");
    #1 rst = 1'b1;
    #1;
    check("rstmid_outs", {bus.bus_req, bus.m_r_en, bus.m_w_en, bus.done_flag}, 0);
    check("rstmid_maddr", bus.m_address, 16'h0);
    check("rstmid_mdout", bus.m_dout, 8'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    repeat (10) @(negedge clk);
    check("rstmid_quiet", rd_a_q.size() + wr_a_q.size(), 0);
    cpu_rd(A_LEN, r); check("rstmid_len", r, 8'h00);

    check("strobe_excl", both_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
